// File: rtl/alertas_pkg.sv
// Shared types and constants for the alert controller: FSM states, class
// indices, per-class RGB on-codes and the class-mask helper.
package alertas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CRITICO = 3'd1,
    ST_AVISO   = 3'd2,
    ST_INFO    = 3'd3,
    ST_PAUSA   = 3'd4
  } estado_t;

  localparam int CRITICO = 2;
  localparam int AVISO   = 1;
  localparam int INFO    = 0;

  // RGB codes are packed {vermelho, verde, azul}
  localparam logic [2:0] RGB_CRITICO = 3'b100;
  localparam logic [2:0] RGB_AVISO   = 3'b110;
  localparam logic [2:0] RGB_INFO    = 3'b001;

  function automatic logic [2:0] mascara_classe(input estado_t e);
    case (e)
      ST_CRITICO: return 3'b100;
      ST_AVISO:   return 3'b010;
      ST_INFO:    return 3'b001;
      default:    return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/controlador_alertas_if.sv
// Request/indicator bundle of the alert controller; master drives requests,
// slave (the controller) drives LEDs, buzzer, busy and ack.
interface controlador_alertas_if;
  logic       req_critico;
  logic       req_aviso;
  logic       req_info;
  logic       silenciar;
  logic       led_vermelho;
  logic       led_verde;
  logic       led_azul;
  logic       buzzer;
  logic       ocupado;
  logic [2:0] ack;

  modport master (
    output req_critico, req_aviso, req_info, silenciar,
    input  led_vermelho, led_verde, led_azul, buzzer, ocupado, ack
  );

  modport slave (
    input  req_critico, req_aviso, req_info, silenciar,
    output led_vermelho, led_verde, led_azul, buzzer, ocupado, ack
  );
endinterface

// File: rtl/controlador_alertas_divisor_pisca.sv
// Blink half-period counter: counts 0..LIMITE-1 while enabled, flags the
// terminal cycle and restarts from zero on request.
module divisor_pisca #(
  parameter int LIMITE = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic habilita_i,
  input  logic reiniciar_i,
  output logic fim_o
);

  localparam int W = (LIMITE > 1) ? $clog2(LIMITE) : 1;
  localparam logic [W-1:0] ULT = W'(LIMITE - 1);

  logic [W-1:0] cont_q;

  assign fim_o = habilita_i && !reiniciar_i && (cont_q == ULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont_q <= {W{1'b0}};
    end else if (reiniciar_i) begin
      cont_q <= {W{1'b0}};
    end else if (habilita_i) begin
      if (fim_o) begin
        cont_q <= {W{1'b0}};
      end else begin
        cont_q <= cont_q + W'(1);
      end
    end else begin
      cont_q <= cont_q;
    end
  end

endmodule

// File: rtl/controlador_alertas.sv
// Prioritised alert sequencer: latches requests into pending flags, plays
// blink sequences on the RGB LED/buzzer, pauses between runs and acks.
module controlador_alertas
  import alertas_pkg::*;
#(
  parameter int MEIO_PERIODO = 25000000,
  parameter int N_PISCADAS   = 3,
  parameter int PAUSA        = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  controlador_alertas_if.slave  bus
);

  localparam int W_MEIA  = (2 * N_PISCADAS > 1) ? $clog2(2 * N_PISCADAS) : 1;
  localparam int W_PAUSA = (PAUSA > 1) ? $clog2(PAUSA) : 1;
  localparam logic [W_MEIA-1:0]  MEIA_ULT  = W_MEIA'(2 * N_PISCADAS - 1);
  localparam logic [W_PAUSA-1:0] PAUSA_ULT = W_PAUSA'(PAUSA - 1);

  estado_t              estado_q;
  logic [W_MEIA-1:0]    meia_q;
  logic [W_PAUSA-1:0]   pausa_q;
  logic [2:0]           pend_q;
  logic [2:0]           ack_q;
  logic [2:0]           req_s;
  logic [2:0]           rgb_s;
  logic                 buzzer_on_s;
  logic                 em_seq_s;
  logic                 preempcao_s;
  logic                 reiniciar_s;
  logic                 fim_meia_s;

  assign req_s = {bus.req_critico, bus.req_aviso, bus.req_info};

  always_comb begin
    em_seq_s    = (estado_q == ST_CRITICO) || (estado_q == ST_AVISO) || (estado_q == ST_INFO);
    preempcao_s = em_seq_s && (estado_q != ST_CRITICO) && pend_q[CRITICO];
    // Held at zero outside a sequence so every entry starts a fresh ON half
    reiniciar_s = !em_seq_s || preempcao_s;
  end

  divisor_pisca #(.LIMITE(MEIO_PERIODO)) u_divisor (
    .clk         (clk),
    .rst         (rst),
    .habilita_i  (em_seq_s),
    .reiniciar_i (reiniciar_s),
    .fim_o       (fim_meia_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= ST_IDLE;
      meia_q   <= {W_MEIA{1'b0}};
      pausa_q  <= {W_PAUSA{1'b0}};
      pend_q   <= 3'b000;
      ack_q    <= 3'b000;
    end else begin
      ack_q <= 3'b000;
      case (estado_q)
        ST_IDLE: begin
          meia_q  <= {W_MEIA{1'b0}};
          pausa_q <= {W_PAUSA{1'b0}};
          if (pend_q[CRITICO]) begin
            estado_q <= ST_CRITICO;
            pend_q   <= (pend_q & 3'b011) | req_s;
          end else if (pend_q[AVISO]) begin
            estado_q <= ST_AVISO;
            pend_q   <= (pend_q & 3'b101) | req_s;
          end else if (pend_q[INFO]) begin
            estado_q <= ST_INFO;
            pend_q   <= (pend_q & 3'b110) | req_s;
          end else begin
            pend_q <= pend_q | req_s;
          end
        end
        ST_CRITICO, ST_AVISO, ST_INFO: begin
          if (preempcao_s) begin
            // Aborted class is re-flagged so it replays once critico is done
            estado_q <= ST_CRITICO;
            meia_q   <= {W_MEIA{1'b0}};
            pend_q   <= (pend_q & 3'b011) | mascara_classe(estado_q) | req_s;
          end else if (fim_meia_s) begin
            pend_q <= pend_q | req_s;
            if (meia_q == MEIA_ULT) begin
              estado_q <= ST_PAUSA;
              meia_q   <= {W_MEIA{1'b0}};
              ack_q    <= mascara_classe(estado_q);
            end else begin
              meia_q <= meia_q + W_MEIA'(1);
            end
          end else begin
            pend_q <= pend_q | req_s;
          end
        end
        ST_PAUSA: begin
          pend_q <= pend_q | req_s;
          if (pausa_q == PAUSA_ULT) begin
            estado_q <= ST_IDLE;
            pausa_q  <= {W_PAUSA{1'b0}};
          end else begin
            pausa_q <= pausa_q + W_PAUSA'(1);
          end
        end
        default: begin
          estado_q <= ST_IDLE;
          meia_q   <= {W_MEIA{1'b0}};
          pausa_q  <= {W_PAUSA{1'b0}};
          pend_q   <= 3'b000;
        end
      endcase
    end
  end

  // Even half index is the ON half
  always_comb begin
    rgb_s       = 3'b000;
    buzzer_on_s = 1'b0;
    if (em_seq_s && (meia_q[0] == 1'b0)) begin
      case (estado_q)
        ST_CRITICO: begin
          rgb_s       = RGB_CRITICO;
          buzzer_on_s = 1'b1;
        end
        ST_AVISO: rgb_s = RGB_AVISO;
        ST_INFO:  rgb_s = RGB_INFO;
        default:  rgb_s = 3'b000;
      endcase
    end else begin
      rgb_s = 3'b000;
    end
  end

  assign bus.led_vermelho = rgb_s[2];
  assign bus.led_verde    = rgb_s[1];
  assign bus.led_azul     = rgb_s[0];
  assign bus.buzzer       = buzzer_on_s & ~bus.silenciar;
  assign bus.ocupado      = (estado_q != ST_IDLE);
  assign bus.ack          = ack_q;

endmodule
